isa_bus_arbiter: RTL and testbench

Sequencer and arbiter for the riser's 8 MHz ISA bus. It shares the bus between host-initiated programmed I/O (PIO) cycles and single-transfer DMA on the four card DMA channels (DRQ1/3/5/7). For each granted cycle it generates the timing for AEN, DACK, IOR and IOW, plus the data and address load strobes. It sits between the register file and the bus interface, and replaces the free-running cycle state machine.

---
 rtl/isa_bus_pkg.sv | 27 ++
 rtl/isa_bus_arbiter_if.sv | 40 ++++
 rtl/rr_arb4.sv | 41 ++++
 rtl/isa_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_isa_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_bus_pkg.sv
// Shared types and timing defaults for the ISA bus cycle arbiter.
// Covers the state enum, channel type and PIO/DMA class encoding.
package isa_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        CLS_PIO = 1'b0,
        CLS_DMA = 1'b1
    } cls_e;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 3;
    localparam int DEF_HOLD_CYCLES   = 1;

    function automatic logic [3:0] chan_onehot(chan_t ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/isa_bus_arbiter_if.sv
// Request/strobe bundle between register file, arbiter and ISA bus.
interface isa_bus_arbiter_if;
    import isa_bus_pkg::*;

    logic [3:0] drq;
    logic [3:0] chan_enable;
    logic [3:0] chan_dir;
    logic [3:0] dma_wdata_valid;
    logic       pio_req;
    logic       pio_write;
    logic       pio_ack;
    logic [3:0] dma_wdata_ack;
    logic       address_load;
    logic       data_load;
    logic       data_capture;
    logic       ior;
    logic       iow;
    logic       aen;
    logic [3:0] dack;
    logic       xfer_done;
    chan_t      xfer_chan;
    logic       xfer_is_dma;

    modport master (
        output drq, chan_enable, chan_dir, dma_wdata_valid,
        output pio_req, pio_write,
        input  pio_ack, dma_wdata_ack, address_load, data_load,
        input  data_capture, ior, iow, aen, dack, xfer_done,
        input  xfer_chan, xfer_is_dma
    );

    modport slave (
        input  drq, chan_enable, chan_dir, dma_wdata_valid,
        input  pio_req, pio_write,
        output pio_ack, dma_wdata_ack, address_load, data_load,
        output data_capture, ior, iow, aen, dack, xfer_done,
        output xfer_chan, xfer_is_dma
    );

endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin picker; the pointer moves past the winner
// only when the caller commits the grant with advance.
module rr_arb4
    import isa_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       advance,
    output logic [3:0] grant,
    output chan_t      idx
);

    chan_t ptr_q, ptr_d;
    chan_t cand;
    logic  found;

    always_comb begin
        found = 1'b0;
        idx   = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + chan_t'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant = found ? chan_onehot(idx) : 4'b0000;
        ptr_d = (advance && found) ? idx + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/isa_bus_arbiter.sv
// ISA bus cycle sequencer: arbitrates PIO against single-transfer DMA
// and times AEN/DACK/IOR/IOW plus data/address strobes per cycle.
module isa_bus_arbiter
    import isa_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input logic              clk,
    input logic              reset,
    isa_bus_arbiter_if.slave bus
);

    localparam int MAX_AB = (SETUP_CYCLES > STROBE_CYCLES) ?
                            SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAXC   = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);

    typedef logic [CW-1:0] cnt_t;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    cls_e       cls_q, cls_d;
    cls_e       last_q, last_d;
    logic       dir_q, dir_d;
    chan_t      chan_q, chan_d;
    logic [3:0] drq_s1_q, drq_s1_d;
    logic [3:0] drq_s2_q, drq_s2_d;

    logic       aen_q, aen_d;
    logic [3:0] dack_q, dack_d;
    logic       ior_q, ior_d;
    logic       iow_q, iow_d;
    logic       addr_ld_q, addr_ld_d;
    logic       data_ld_q, data_ld_d;
    logic       capture_q, capture_d;
    logic       done_q, done_d;
    logic       pio_ack_q, pio_ack_d;
    logic [3:0] wack_q, wack_d;

    logic [3:0] eligible;
    logic [3:0] rr_gnt;
    chan_t      rr_idx;
    logic       advance;
    logic       pio_pend, dma_pend;
    logic       grant_pio, grant_dma;
    logic       active, is_dma, last_hold;

    assign eligible = drq_s2_q & bus.chan_enable
                    & (bus.chan_dir | bus.dma_wdata_valid);
    assign pio_pend = bus.pio_req;
    assign dma_pend = |rr_gnt;

    rr_arb4 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (advance),
        .grant   (rr_gnt),
        .idx     (rr_idx)
    );

    always_comb begin
        drq_s1_d  = bus.drq;
        drq_s2_d  = drq_s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        cls_d     = cls_q;
        last_d    = last_q;
        dir_d     = dir_q;
        chan_d    = chan_q;
        advance   = 1'b0;
        grant_pio = 1'b0;
        grant_dma = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // On a conflict the class not served last wins.
                if (pio_pend && dma_pend) begin
                    grant_dma = (last_q == CLS_PIO);
                    grant_pio = !grant_dma;
                end else begin
                    grant_pio = pio_pend;
                    grant_dma = dma_pend;
                end
                if (grant_pio) begin
                    cls_d = CLS_PIO;
                    dir_d = bus.pio_write;
                end
                if (grant_dma) begin
                    cls_d   = CLS_DMA;
                    chan_d  = rr_idx;
                    dir_d   = !bus.chan_dir[rr_idx];
                    advance = 1'b1;
                end
                if (grant_pio || grant_dma) begin
                    last_d  = cls_d;
                    state_d = S_SETUP;
                    cnt_d   = cnt_t'(SETUP_CYCLES);
                end
            end
            S_SETUP: begin
                if (cnt_q == cnt_t'(1)) begin
                    state_d = S_STROBE;
                    cnt_d   = cnt_t'(STROBE_CYCLES);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == cnt_t'(1)) begin
                    state_d = S_HOLD;
                    cnt_d   = cnt_t'(HOLD_CYCLES);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == cnt_t'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave registered.
    always_comb begin
        active    = (state_d != S_IDLE);
        is_dma    = (cls_d == CLS_DMA);
        last_hold = (state_d == S_HOLD) && (cnt_d == cnt_t'(1));
        aen_d     = active && is_dma;
        dack_d    = aen_d ? chan_onehot(chan_d) : 4'b0000;
        addr_ld_d = !is_dma && (state_d == S_SETUP)
                 && (cnt_d == cnt_t'(SETUP_CYCLES));
        data_ld_d = dir_d
                 && ((state_d == S_SETUP) || (state_d == S_STROBE));
        ior_d     = !dir_d && (state_d == S_STROBE);
        iow_d     = dir_d && (state_d == S_STROBE);
        capture_d = ior_d && (cnt_d == cnt_t'(1));
        done_d    = last_hold;
        pio_ack_d = last_hold && !is_dma;
        wack_d    = (last_hold && is_dma && dir_d) ?
                    chan_onehot(chan_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cls_q     <= CLS_PIO;
            last_q    <= CLS_PIO;
            dir_q     <= 1'b0;
            chan_q    <= '0;
            drq_s1_q  <= '0;
            drq_s2_q  <= '0;
            aen_q     <= 1'b0;
            dack_q    <= '0;
            ior_q     <= 1'b0;
            iow_q     <= 1'b0;
            addr_ld_q <= 1'b0;
            data_ld_q <= 1'b0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            pio_ack_q <= 1'b0;
            wack_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cls_q     <= cls_d;
            last_q    <= last_d;
            dir_q     <= dir_d;
            chan_q    <= chan_d;
            drq_s1_q  <= drq_s1_d;
            drq_s2_q  <= drq_s2_d;
            aen_q     <= aen_d;
            dack_q    <= dack_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            addr_ld_q <= addr_ld_d;
            data_ld_q <= data_ld_d;
            capture_q <= capture_d;
            done_q    <= done_d;
            pio_ack_q <= pio_ack_d;
            wack_q    <= wack_d;
        end
    end

    assign bus.aen           = aen_q;
    assign bus.dack          = dack_q;
    assign bus.ior           = ior_q;
    assign bus.iow           = iow_q;
    assign bus.address_load  = addr_ld_q;
    assign bus.data_load     = data_ld_q;
    assign bus.data_capture  = capture_q;
    assign bus.xfer_done     = done_q;
    assign bus.pio_ack       = pio_ack_q;
    assign bus.dma_wdata_ack = wack_q;
    assign bus.xfer_chan     = chan_q;
    assign bus.xfer_is_dma   = (cls_q == CLS_DMA);

endmodule

// File: tb/tb_isa_bus_arbiter.sv
// Bench for isa_bus_arbiter: table of held-request scenarios checked
// clock by clock from a queue, plus hand-written corner sequences.
module tb_isa_bus_arbiter;
    import isa_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    isa_bus_arbiter_if bus ();

    isa_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       aen;
        logic [3:0] dack;
        logic       ior;
        logic       iow;
        logic       address_load;
        logic       data_load;
        logic       data_capture;
        logic       xfer_done;
        logic       pio_ack;
        logic [3:0] wack;
        logic [1:0] xfer_chan;
        logic       xfer_is_dma;
    } obs_t;

    typedef struct {
        logic       pio_req;
        logic       pio_write;
        logic [3:0] drq;
        logic [3:0] en;
        logic [3:0] dir;
        logic [3:0] wv;
        int         n;
        logic [3:0] g_dma;
        logic [7:0] g_ch;
        logic [3:0] g_wr;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    obs_t  sb[$];
    chan_t exp_chan;
    vec_t  vecs[8];

    function automatic obs_t sample();
        obs_t o;
        o.aen          = bus.aen;
        o.dack         = bus.dack;
        o.ior          = bus.ior;
        o.iow          = bus.iow;
        o.address_load = bus.address_load;
        o.data_load    = bus.data_load;
        o.data_capture = bus.data_capture;
        o.xfer_done    = bus.xfer_done;
        o.pio_ack      = bus.pio_ack;
        o.wack         = bus.dma_wdata_ack;
        o.xfer_chan    = bus.xfer_chan;
        o.xfer_is_dma  = bus.xfer_is_dma;
        return o;
    endfunction

    task automatic check_obs(string nm, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_val(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.drq             = '0;
        bus.chan_enable     = '0;
        bus.chan_dir        = '0;
        bus.dma_wdata_valid = '0;
        bus.pio_req         = 1'b0;
        bus.pio_write       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        check_obs("reset_state", sample(), '0);
        reset = 1'b0;
        exp_chan = '0;
    endtask

    // Expected outputs for one default-timing cycle plus its idle clock.
    task automatic push_grant(bit dma, chan_t ch, bit wr);
        obs_t  e;
        chan_t xc;
        xc = dma ? ch : exp_chan;
        for (int c = 1; c <= 6; c++) begin
            e              = '0;
            e.aen          = dma && (c <= 5);
            e.dack         = (dma && c <= 5) ? (4'b0001 << ch) : 4'b0000;
            e.address_load = !dma && (c == 1);
            e.data_load    = wr && (c <= 4);
            e.ior          = !wr && (c >= 2) && (c <= 4);
            e.iow          = wr && (c >= 2) && (c <= 4);
            e.data_capture = !wr && (c == 4);
            e.xfer_done    = (c == 5);
            e.pio_ack      = !dma && (c == 5);
            e.wack         = (dma && wr && c == 5) ? (4'b0001 << ch) : 4'b0;
            e.xfer_chan    = xc;
            e.xfer_is_dma  = dma;
            sb.push_back(e);
        end
        if (dma) exp_chan = ch;
    endtask

    task automatic wait_active(string nm, output obs_t a, output bit ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            a  = sample();
            ok = a.aen | a.address_load | a.data_load;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: no cycle started within 20 clocks", nm);
        end
    endtask

    task automatic run_sb(string nm);
        obs_t a;
        bit   ok;
        wait_active(nm, a, ok);
        if (!ok) begin
            sb.delete();
            return;
        end
        while (sb.size() > 0) begin
            check_obs(nm, a, sb.pop_front());
            if (sb.size() > 0) begin
                @(negedge clk);
                a = sample();
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((bus.ior && bus.iow) || !$onehot0(bus.dack)
                || (bus.dack != 4'b0 && !bus.aen)) begin
                errors++;
                $display("FAIL invariant: ior=%b iow=%b aen=%b dack=%b want exclusive strobes, onehot dack under aen",
                         bus.ior, bus.iow, bus.aen, bus.dack);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t a;
        bit   ok;
        int   n_aen, n_ior, n_iow, n_done, n_wack, n_al;

        clear_inputs();
        // pio_req, pio_write, drq, en, dir, wv, n, g_dma, g_ch, g_wr
        vecs[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2, 4'b0000, 8'h00, 4'b0000};
        vecs[1] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2, 4'b0000, 8'h00, 4'b0011};
        vecs[2] = '{1'b0, 1'b0, 4'h5, 4'hF, 4'hF, 4'h0, 3, 4'b0111, 8'h08, 4'b0000};
        vecs[3] = '{1'b0, 1'b0, 4'h2, 4'hF, 4'h0, 4'h2, 2, 4'b0011, 8'h05, 4'b0011};
        vecs[4] = '{1'b1, 1'b0, 4'h8, 4'hF, 4'hF, 4'h0, 4, 4'b0101, 8'h33, 4'b0000};
        vecs[5] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h5, 4'hF, 3, 4'b0111, 8'h24, 4'b0010};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 4'hA, 4'hF, 4'h0, 3, 4'b0111, 8'h1D, 4'b0000};
        vecs[7] = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 2, 4'b0011, 8'h0A, 4'b0011};

        for (int r = 0; r < 8; r++) begin
            logic [7:0] chs;
            do_reset();
            bus.drq             = vecs[r].drq;
            bus.chan_enable     = vecs[r].en;
            bus.chan_dir        = vecs[r].dir;
            bus.dma_wdata_valid = vecs[r].wv;
            chs = vecs[r].g_ch;
            for (int g = 0; g < vecs[r].n; g++) begin
                push_grant(vecs[r].g_dma[g], chan_t'(chs[2*g +: 2]),
                           vecs[r].g_wr[g]);
            end
            // Let DRQ clear the synchronizer so PIO and DMA meet in IDLE.
            @(negedge clk);
            @(negedge clk);
            bus.pio_req   = vecs[r].pio_req;
            bus.pio_write = vecs[r].pio_write;
            run_sb($sformatf("row%0d", r));
        end

        // PIO is granted on the first edge; DRQ needs two more.
        do_reset();
        bus.pio_req = 1'b1;
        @(negedge clk);
        check_val("pio_latency", int'(bus.address_load), 1);
        do_reset();
        bus.drq         = 4'b0001;
        bus.chan_enable = 4'hF;
        bus.chan_dir    = 4'hF;
        @(negedge clk);
        check_val("drq_lat_c1", int'(bus.aen), 0);
        @(negedge clk);
        check_val("drq_lat_c2", int'(bus.aen), 0);
        @(negedge clk);
        check_val("drq_lat_c3", int'(bus.aen), 1);

        // Write channel without staged data must not be granted.
        do_reset();
        bus.drq         = 4'b0010;
        bus.chan_enable = 4'hF;
        n_aen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_aen += int'(bus.aen | bus.iow);
        end
        check_val("wr_no_data", n_aen, 0);
        bus.dma_wdata_valid = 4'b0010;
        n_aen = 0; n_iow = 0; n_wack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_aen  += int'(bus.aen);
            n_iow  += int'(bus.iow);
            n_wack += int'(bus.dma_wdata_ack == 4'b0010);
        end
        check_val("wr_aen_cnt", n_aen, 5);
        check_val("wr_iow_cnt", n_iow, 3);
        check_val("wr_ack_cnt", n_wack, 1);

        // DRQ dropping mid-strobe does not cut the cycle short.
        do_reset();
        bus.drq         = 4'b0100;
        bus.chan_enable = 4'hF;
        bus.chan_dir    = 4'hF;
        wait_active("drop_start", a, ok);
        n_aen  = int'(a.aen);
        n_ior  = int'(a.ior);
        n_done = int'(a.xfer_done);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_aen  += int'(bus.aen);
            n_ior  += int'(bus.ior);
            n_done += int'(bus.xfer_done);
            if (i == 0) bus.drq = 4'b0000;
        end
        check_val("drop_aen_cnt", n_aen, 5);
        check_val("drop_ior_cnt", n_ior, 3);
        check_val("drop_done_cnt", n_done, 1);

        // Reset mid-strobe clears outputs and the round-robin pointer.
        do_reset();
        bus.drq         = 4'b0010;
        bus.chan_enable = 4'hF;
        bus.chan_dir    = 4'hF;
        wait_active("rst_start", a, ok);
        @(negedge clk);
        check_val("rst_in_strobe", int'(bus.ior), 1);
        reset = 1'b1;
        @(negedge clk);
        check_obs("reset_mid", sample(), '0);
        reset    = 1'b0;
        bus.drq  = 4'b0101;
        wait_active("ptr_start", a, ok);
        check_val("ptr_reset", int'(a.dack), 1);

        // A PIO request withdrawn before IDLE is never granted.
        do_reset();
        bus.drq         = 4'b0001;
        bus.chan_enable = 4'hF;
        bus.chan_dir    = 4'hF;
        wait_active("wd_start", a, ok);
        bus.drq     = 4'b0000;
        bus.pio_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.pio_req = 1'b0;
        n_al = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_al += int'(bus.address_load);
        end
        check_val("pio_withdraw", n_al, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
